packet_integrity_checker: RTL and testbench

Upstream stage of the NI fault classifier: monitors the flit stream delivered to the NI and issues exactly one verdict pulse per received packet.
- Healthy_packet: packet intact.
- faulty_packet: any error detected.
Checks per-flit parity, flit-type sequencing, header length field and inter-flit timeout. Its two pulse outputs drive the classifier's faulty_packet / Healthy_packet inputs directly.

---
 rtl/packet_integrity_checker_pkg.sv | 31 +++
 rtl/packet_integrity_checker_if.sv | 26 ++
 rtl/packet_integrity_checker_timeout.sv | 29 ++
 rtl/packet_integrity_checker.sv | 148 ++++++++++++++
 tb/tb_packet_integrity_checker.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/packet_integrity_checker_pkg.sv
// Shared definitions for the packet integrity checker: flit type codes,
// verdict error codes, FSM state encoding and the verdict priority helper.
package packet_integrity_checker_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_PARITY     = 3'd1;
  localparam logic [2:0] ERR_TYPE       = 3'd2;
  localparam logic [2:0] ERR_LENGTH     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
  localparam logic [2:0] ERR_STRAY_TAIL = 3'd5;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // Collapse the sticky per-packet flags into a single code; parity wins,
  // then type, then length. ERR_NONE means the packet is healthy.
  function automatic logic [2:0] verdict_code(input logic par, input logic typ,
                                              input logic len);
    if (par)      return ERR_PARITY;
    else if (typ) return ERR_TYPE;
    else if (len) return ERR_LENGTH;
    else          return ERR_NONE;
  endfunction

endpackage

// File: rtl/packet_integrity_checker_if.sv
// Flit stream into the checker and the verdict outputs back out.
//   valid_in, flit_in            : flit stream (master drives)
//   faulty_packet, Healthy_packet: one-cycle verdict pulses (slave drives)
//   error_code                   : cause of the last faulty verdict
//   stray_count                  : saturating count of stray body flits
interface packet_integrity_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int STRAY_W    = 8
) ();
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  faulty_packet;
  logic                  Healthy_packet;
  logic [2:0]            error_code;
  logic [STRAY_W-1:0]    stray_count;

  modport master (
    output valid_in, flit_in,
    input  faulty_packet, Healthy_packet, error_code, stray_count
  );

  modport slave (
    input  valid_in, flit_in,
    output faulty_packet, Healthy_packet, error_code, stray_count
  );
endinterface

// File: rtl/packet_integrity_checker_timeout.sv
// Inter-flit idle counter.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count (flit seen, or not inside a packet)
//   enable     : an idle cycle inside a packet
//   expired    : this idle cycle is the TIMEOUT-th consecutive one
module packet_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable && (count != W'(TIMEOUT)))
      count <= count + W'(1);
  end

  // Combinational so the FSM can act in the expiry cycle itself; a valid
  // flit in that cycle drops enable and therefore suppresses expiry.
  assign expired = enable && (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/packet_integrity_checker.sv
// Monitors the flit stream into the NI and emits exactly one verdict pulse
// per packet (Healthy_packet or faulty_packet, registered, one cycle after
// the terminating flit or timeout cycle).
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of packet_integrity_checker_if
module packet_integrity_checker
  import packet_integrity_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 12,
  parameter int TIMEOUT    = 64,
  parameter int STRAY_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  packet_integrity_checker_if.slave   bus
);
  state_t             state, state_n;
  logic [LEN_W-1:0]   cnt, cnt_n, len, len_n;
  logic               par_err, par_err_n, typ_err, typ_err_n, len_err, len_err_n;
  logic               faulty, faulty_n, healthy, healthy_n;
  logic [2:0]         code, code_n;
  logic [STRAY_W-1:0] stray, stray_n;

  logic [2:0]         ftype;
  logic [LEN_W-1:0]   flen;
  logic               par_bad, expired, hdr_start;
  logic [LEN_W:0]     cnt_plus;
  logic [LEN_W-1:0]   cnt_inc;
  logic [2:0]         tail_code;

  assign ftype    = bus.flit_in[DATA_WIDTH-1 -: 3];
  assign flen     = bus.flit_in[DATA_WIDTH-4 -: LEN_W];
  assign par_bad  = ^bus.flit_in;
  // One bit wider so a saturated counter can never equal any length value.
  assign cnt_plus = {1'b0, cnt} + (LEN_W+1)'(1);
  assign cnt_inc  = (&cnt) ? cnt : cnt + LEN_W'(1);
  assign tail_code = verdict_code(par_err | par_bad, typ_err,
                                  len_err | (cnt_plus != {1'b0, len}));

  packet_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state != IN_PKT) || bus.valid_in),
    .enable  ((state == IN_PKT) && !bus.valid_in),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      len     <= '0;
      par_err <= 1'b0;
      typ_err <= 1'b0;
      len_err <= 1'b0;
      faulty  <= 1'b0;
      healthy <= 1'b0;
      code    <= ERR_NONE;
      stray   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len     <= len_n;
      par_err <= par_err_n;
      typ_err <= typ_err_n;
      len_err <= len_err_n;
      faulty  <= faulty_n;
      healthy <= healthy_n;
      code    <= code_n;
      stray   <= stray_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    len_n     = len;
    par_err_n = par_err;
    typ_err_n = typ_err;
    len_err_n = len_err;
    faulty_n  = 1'b0;
    healthy_n = 1'b0;
    code_n    = code;
    stray_n   = stray;
    hdr_start = 1'b0;

    case (state)
      IDLE: begin
        if (bus.valid_in) begin
          if (ftype == FLIT_HEADER) begin
            hdr_start = 1'b1;
          end else if (ftype == FLIT_BODY) begin
            stray_n = (&stray) ? stray : stray + STRAY_W'(1);
          end else begin
            faulty_n = 1'b1;
            code_n   = ERR_STRAY_TAIL;
          end
        end
      end
      IN_PKT: begin
        if (bus.valid_in) begin
          if (ftype == FLIT_HEADER) begin
            // Previous packet was cut short by a new header.
            faulty_n  = 1'b1;
            code_n    = ERR_TYPE;
            hdr_start = 1'b1;
          end else if (ftype == FLIT_TAIL) begin
            state_n = IDLE;
            if (tail_code == ERR_NONE) begin
              healthy_n = 1'b1;
            end else begin
              faulty_n = 1'b1;
              code_n   = tail_code;
            end
          end else begin
            cnt_n = cnt_inc;
            if (par_bad) par_err_n = 1'b1;
            if (ftype == FLIT_BODY) begin
              if (cnt_plus >= {1'b0, len}) len_err_n = 1'b1;
            end else begin
              typ_err_n = 1'b1;
            end
          end
        end else if (expired) begin
          faulty_n = 1'b1;
          code_n   = ERR_TIMEOUT;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (hdr_start) begin
      state_n   = IN_PKT;
      cnt_n     = LEN_W'(1);
      len_n     = flen;
      par_err_n = par_bad;
      typ_err_n = 1'b0;
      len_err_n = (flen < LEN_W'(2));
    end
  end

  assign bus.faulty_packet  = faulty;
  assign bus.Healthy_packet = healthy;
  assign bus.error_code     = code;
  assign bus.stray_count    = stray;
endmodule

// File: tb/tb_packet_integrity_checker.sv
module tb_packet_integrity_checker;
  localparam int TIMEOUT = 64;
  localparam logic [2:0] H = 3'b001, B = 3'b010, T = 3'b100, BAD = 3'b011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  packet_integrity_checker_if #(.DATA_WIDTH(32), .STRAY_W(8)) bus ();

  packet_integrity_checker #(
    .DATA_WIDTH(32), .LEN_W(12), .TIMEOUT(TIMEOUT), .STRAY_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: tracks the open packet as a flit count plus
  // "any bad parity" / "any illegal type" facts and judges it when it ends.
  bit m_on = 0, m_in_pkt = 0;
  int m_n, m_len, m_idle, m_stray, e_code;
  bit m_par, m_typ, e_f, e_h;

  always @(posedge clk) begin
    logic [2:0] t;
    bit p;
    int c;
    e_f = 0;
    e_h = 0;
    if (reset) begin
      m_on = 1; m_in_pkt = 0; m_stray = 0; e_code = 0; m_idle = 0;
    end else if (bus.valid_in) begin
      t = bus.flit_in[31:29];
      p = ^bus.flit_in;
      m_idle = 0;
      if (t == H) begin
        if (m_in_pkt) begin e_f = 1; e_code = 2; end
        m_in_pkt = 1; m_n = 1; m_len = int'(bus.flit_in[28:17]);
        m_par = p; m_typ = 0;
      end else if (!m_in_pkt) begin
        if (t == B) m_stray = (m_stray < 255) ? m_stray + 1 : 255;
        else begin e_f = 1; e_code = 5; end
      end else begin
        m_n++;
        m_par |= p;
        if (t != B && t != T) m_typ = 1;
        if (t == T) begin
          c = m_par ? 1 : m_typ ? 2 : (m_len < 2 || m_n != m_len) ? 3 : 0;
          if (c == 0) e_h = 1;
          else begin e_f = 1; e_code = c; end
          m_in_pkt = 0;
        end
      end
    end else if (m_in_pkt) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin e_f = 1; e_code = 4; m_in_pkt = 0; m_idle = 0; end
    end
  end

  int n_f = 0, n_h = 0;
  always @(negedge clk) begin
    if (m_on) begin
      chk("faulty_packet", 32'(bus.faulty_packet), 32'(e_f));
      chk("Healthy_packet", 32'(bus.Healthy_packet), 32'(e_h));
      chk("error_code", 32'(bus.error_code), 32'(e_code));
      chk("stray_count", 32'(bus.stray_count), 32'(m_stray));
      if (bus.faulty_packet === 1'b1) n_f++;
      if (bus.Healthy_packet === 1'b1) n_h++;
    end
  end

  function automatic logic [31:0] mk(input logic [2:0] t, input int len, input int pay);
    logic [31:0] f;
    f = {t, 12'(len), 17'(pay)};
    f[0] = 1'b0;
    f[0] = ^f;
    return f;
  endfunction

  task automatic send(input logic [31:0] f);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.flit_in  = f;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.flit_in  = '0;
    end
  endtask

  int f0, h0;
  task automatic snap();
    f0 = n_f;
    h0 = n_h;
  endtask

  task automatic expect_pulses(input string name, input int df, input int dh, input int code);
    idle(2);
    #2;
    chk({name, " faulty pulses"}, 32'(n_f - f0), 32'(df));
    chk({name, " healthy pulses"}, 32'(n_h - h0), 32'(dh));
    if (code >= 0) chk({name, " code"}, 32'(bus.error_code), 32'(code));
  endtask

  initial begin
    logic [31:0] fl;
    bus.valid_in = 1'b0;
    bus.flit_in  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("reset faulty", 32'(bus.faulty_packet), 0);
    chk("reset healthy", 32'(bus.Healthy_packet), 0);
    chk("reset code", 32'(bus.error_code), 0);
    chk("reset stray", 32'(bus.stray_count), 0);
    reset = 1'b0;

    snap();
    send(mk(H, 4, 1)); send(mk(B, 0, 2)); send(mk(B, 0, 3)); send(mk(T, 0, 4));
    expect_pulses("clean len4", 0, 1, 0);

    snap();
    fl = mk(B, 0, 3);
    fl[0] = ~fl[0];
    send(mk(H, 4, 1)); send(mk(B, 0, 2)); send(fl); send(mk(T, 0, 4));
    expect_pulses("parity", 1, 0, 1);

    snap();
    send(mk(H, 4, 1)); send(mk(B, 0, 2)); send(mk(T, 0, 3));
    expect_pulses("short", 1, 0, 3);

    snap();
    send(mk(H, 3, 1)); send(mk(B, 0, 2)); send(mk(B, 0, 3)); send(mk(B, 0, 4)); send(mk(T, 0, 5));
    expect_pulses("long", 1, 0, 3);

    snap();
    send(mk(H, 4, 1)); send(mk(B, 0, 2)); send(mk(BAD, 0, 3)); send(mk(T, 0, 4));
    expect_pulses("illegal type", 1, 0, 2);

    snap();
    fl = mk(B, 0, 3);
    fl[0] = ~fl[0];
    send(mk(H, 5, 1)); send(fl); send(mk(T, 0, 4));
    expect_pulses("parity over length", 1, 0, 1);

    snap();
    send(mk(H, 3, 1)); send(mk(B, 0, 2));
    idle(63);
    idle(1);
    #2;
    chk("timeout early", 32'(n_f - f0), 0);
    idle(1);
    #2;
    chk("timeout pulse", 32'(n_f - f0), 1);
    chk("timeout code", 32'(bus.error_code), 4);

    snap();
    send(mk(H, 3, 1)); send(mk(B, 0, 2));
    idle(63);
    send(mk(T, 0, 3));
    expect_pulses("tail at expiry", 0, 1, 4);

    snap();
    send(mk(H, 4, 1)); send(mk(B, 0, 2)); send(mk(H, 2, 3));
    idle(1);
    #2;
    chk("header cut faulty", 32'(n_f - f0), 1);
    chk("header cut code", 32'(bus.error_code), 2);
    snap();
    send(mk(T, 0, 4));
    expect_pulses("packet B", 0, 1, 2);

    snap();
    repeat (300) send(mk(B, 0, 7));
    expect_pulses("strays", 0, 0, 2);
    chk("stray saturate", 32'(bus.stray_count), 255);

    snap();
    send(mk(T, 0, 1));
    expect_pulses("stray tail", 1, 0, 5);

    snap();
    send(mk(H, 4, 1)); send(mk(B, 0, 2));
    @(negedge clk);
    reset = 1'b1;
    bus.valid_in = 1'b0;
    @(negedge clk);
    #2;
    chk("midreset faulty", 32'(bus.faulty_packet), 0);
    chk("midreset healthy", 32'(bus.Healthy_packet), 0);
    chk("midreset code", 32'(bus.error_code), 0);
    chk("midreset stray", 32'(bus.stray_count), 0);
    reset = 1'b0;
    idle(TIMEOUT + 6);
    #2;
    chk("midreset no pulse", 32'(n_f - f0 + n_h - h0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
